// File: rtl/pipe_hazard_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : pipe_hazard_ctrl
//  Purpose  : Stall/flush scheduler for a 5-stage RISC-V pipeline. Resolves
//             load-use hazards, EX-stage redirects and multi-cycle mul/div
//             holds, and keeps saturating stall/flush performance counters.
//  Revision : 1.0 - initial release
// ============================================================================
module pipe_hazard_ctrl #(
  parameter int MD_TIMEOUT = 64,
  parameter int CNT_W      = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [4:0]       id_rs1,
  input  logic [4:0]       id_rs2,
  input  logic             id_use_rs1,
  input  logic             id_use_rs2,
  input  logic [4:0]       ex_rd,
  input  logic             ex_mem_read,
  input  logic             ex_redirect,
  input  logic             ex_md_start,
  input  logic             md_done,
  output logic             pc_stall,
  output logic             if_id_stall,
  output logic             if_id_flush,
  output logic             id_ex_stall,
  output logic             id_ex_bubble,
  output logic             ex_mem_bubble,
  output logic             md_timeout,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  // md_cyc only ever counts 0 .. MD_TIMEOUT-1
  localparam int                 C_CYC_W   = (MD_TIMEOUT > 1) ? $clog2(MD_TIMEOUT) : 1;
  localparam logic [C_CYC_W-1:0] C_MD_LAST = C_CYC_W'(MD_TIMEOUT - 1);
  localparam logic [C_CYC_W-1:0] C_MD_ONE  = C_CYC_W'(1);
  localparam logic [CNT_W-1:0]   C_CNT_MAX = '1;
  localparam logic [CNT_W-1:0]   C_CNT_ONE = CNT_W'(1);

  // A timeout shorter than two cycles leaves no room for the busy window
  generate
    if (MD_TIMEOUT < 2) begin : g_param_check
      $error("pipe_hazard_ctrl: MD_TIMEOUT must be at least 2");
    end
  endgenerate

  typedef enum logic [0:0] {
    ST_RUN     = 1'b0,
    ST_MD_BUSY = 1'b1
  } state_e;

  state_e             state_q, state_d;
  logic [C_CYC_W-1:0] md_cyc_q, md_cyc_d;
  logic               md_timeout_q, md_timeout_d;
  logic [CNT_W-1:0]   stall_cnt_q, stall_cnt_d;
  logic [CNT_W-1:0]   flush_cnt_q, flush_cnt_d;
  logic               w_lu;
  logic               w_flush_acc;

  // Load-use: the load in EX writes a register the ID instruction reads (x0 never hazards)
  always_comb begin
    w_lu = ex_mem_read && (ex_rd != 5'd0) &&
           ((id_use_rs1 && (id_rs1 == ex_rd)) || (id_use_rs2 && (id_rs2 == ex_rd)));
  end

  // Next-state and control outputs; everything held low while in reset
  always_comb begin
    state_d       = state_q;
    md_cyc_d      = md_cyc_q;
    md_timeout_d  = 1'b0;
    w_flush_acc   = 1'b0;
    pc_stall      = 1'b0;
    if_id_stall   = 1'b0;
    if_id_flush   = 1'b0;
    id_ex_stall   = 1'b0;
    id_ex_bubble  = 1'b0;
    ex_mem_bubble = 1'b0;

    if (!rst) begin
      case (state_q)
        ST_RUN: begin
          if (ex_redirect) begin
            // Wrong-path instruction in ID is squashed, so any load-use is moot
            if_id_flush  = 1'b1;
            id_ex_bubble = 1'b1;
            w_flush_acc  = 1'b1;
          end else if (ex_md_start && !md_done) begin
            pc_stall      = 1'b1;
            if_id_stall   = 1'b1;
            id_ex_stall   = 1'b1;
            ex_mem_bubble = 1'b1;
            state_d       = ST_MD_BUSY;
            md_cyc_d      = C_MD_ONE;
          end else if (ex_md_start && md_done) begin
            // Single-cycle result: let it flow without stalling
            state_d = ST_RUN;
          end else if (w_lu) begin
            // One-cycle hold; the bubble in EX clears the hazard next cycle
            pc_stall     = 1'b1;
            if_id_stall  = 1'b1;
            id_ex_bubble = 1'b1;
          end
        end

        ST_MD_BUSY: begin
          if (md_done) begin
            state_d  = ST_RUN;
            md_cyc_d = '0;
          end else if (md_cyc_q == C_MD_LAST) begin
            // Forced release: same outputs as a done cycle, plus a flag
            state_d      = ST_RUN;
            md_cyc_d     = '0;
            md_timeout_d = 1'b1;
          end else begin
            pc_stall      = 1'b1;
            if_id_stall   = 1'b1;
            id_ex_stall   = 1'b1;
            ex_mem_bubble = 1'b1;
            md_cyc_d      = md_cyc_q + C_MD_ONE;
          end
        end

        default: begin
          state_d  = ST_RUN;
          md_cyc_d = '0;
        end
      endcase
    end
  end

  // Saturating performance counters
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    if (pc_stall && (stall_cnt_q != C_CNT_MAX)) begin
      stall_cnt_d = stall_cnt_q + C_CNT_ONE;
    end
    if (w_flush_acc && (flush_cnt_q != C_CNT_MAX)) begin
      flush_cnt_d = flush_cnt_q + C_CNT_ONE;
    end
  end

  // State, timeout pulse and counter registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_RUN;
      md_cyc_q     <= '0;
      md_timeout_q <= 1'b0;
      stall_cnt_q  <= '0;
      flush_cnt_q  <= '0;
    end else begin
      state_q      <= state_d;
      md_cyc_q     <= md_cyc_d;
      md_timeout_q <= md_timeout_d;
      stall_cnt_q  <= stall_cnt_d;
      flush_cnt_q  <= flush_cnt_d;
    end
  end

  assign md_timeout = md_timeout_q;
  assign stall_cnt  = stall_cnt_q;
  assign flush_cnt  = flush_cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_pipe_hazard_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_pipe_hazard_ctrl
//  Purpose  : Self-checking bench for pipe_hazard_ctrl with a cycle-level
//             reference model of the hazard rules.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_pipe_hazard_ctrl;

  localparam int C_TMO = 8;
  localparam int C_CW  = 16;
  localparam int C_CWS = 3;
  localparam longint C_MAX  = (longint'(1) << C_CW) - 1;
  localparam longint C_MAXS = (longint'(1) << C_CWS) - 1;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst;
  logic [4:0] id_rs1, id_rs2, ex_rd;
  logic       id_use_rs1, id_use_rs2, ex_mem_read, ex_redirect, ex_md_start, md_done;

  logic            pc_stall, if_id_stall, if_id_flush, id_ex_stall, id_ex_bubble, ex_mem_bubble;
  logic            md_timeout;
  logic [C_CW-1:0] stall_cnt, flush_cnt;

  logic             s_pc_stall, s_if_id_stall, s_if_id_flush, s_id_ex_stall, s_id_ex_bubble, s_ex_mem_bubble;
  logic             s_md_timeout;
  logic [C_CWS-1:0] s_stall_cnt, s_flush_cnt;

  wire [5:0] ctrl   = {pc_stall, if_id_stall, if_id_flush, id_ex_stall, id_ex_bubble, ex_mem_bubble};
  wire [5:0] s_ctrl = {s_pc_stall, s_if_id_stall, s_if_id_flush, s_id_ex_stall, s_id_ex_bubble, s_ex_mem_bubble};

  pipe_hazard_ctrl #(.MD_TIMEOUT(C_TMO), .CNT_W(C_CW)) dut (
    .clk(clk), .rst(rst),
    .id_rs1(id_rs1), .id_rs2(id_rs2), .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2),
    .ex_rd(ex_rd), .ex_mem_read(ex_mem_read), .ex_redirect(ex_redirect),
    .ex_md_start(ex_md_start), .md_done(md_done),
    .pc_stall(pc_stall), .if_id_stall(if_id_stall), .if_id_flush(if_id_flush),
    .id_ex_stall(id_ex_stall), .id_ex_bubble(id_ex_bubble), .ex_mem_bubble(ex_mem_bubble),
    .md_timeout(md_timeout), .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
  );

  pipe_hazard_ctrl #(.MD_TIMEOUT(C_TMO), .CNT_W(C_CWS)) dut_sat (
    .clk(clk), .rst(rst),
    .id_rs1(id_rs1), .id_rs2(id_rs2), .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2),
    .ex_rd(ex_rd), .ex_mem_read(ex_mem_read), .ex_redirect(ex_redirect),
    .ex_md_start(ex_md_start), .md_done(md_done),
    .pc_stall(s_pc_stall), .if_id_stall(s_if_id_stall), .if_id_flush(s_if_id_flush),
    .id_ex_stall(s_id_ex_stall), .id_ex_bubble(s_id_ex_bubble), .ex_mem_bubble(s_ex_mem_bubble),
    .md_timeout(s_md_timeout), .stall_cnt(s_stall_cnt), .flush_cnt(s_flush_cnt)
  );

  int tests  = 0;
  int failed = 0;

  // Reference model: is a mul/div op outstanding, and how many cycles it has held the pipe
  bit     m_busy;
  int     m_held;
  bit     m_tmo;
  longint m_stall, m_flush, m_stall_s, m_flush_s;

  logic [5:0] exp_ctrl;
  bit         e_busy_n, e_tmo_n, e_flush;
  int         e_held_n;

  // Expected controls for the current inputs, and what the next cycle looks like
  task automatic eval_model();
    bit lu;
    lu = ex_mem_read && (ex_rd != 0) &&
         ((id_use_rs1 && id_rs1 == ex_rd) || (id_use_rs2 && id_rs2 == ex_rd));
    exp_ctrl = 6'b000000;
    e_busy_n = m_busy;
    e_held_n = m_held;
    e_tmo_n  = 1'b0;
    e_flush  = 1'b0;
    if (rst) begin
      e_busy_n = 1'b0;
      e_held_n = 0;
    end else if (!m_busy) begin
      if (ex_redirect) begin
        exp_ctrl = 6'b001010;
        e_flush  = 1'b1;
      end else if (ex_md_start && !md_done) begin
        exp_ctrl = 6'b110101;
        e_busy_n = 1'b1;
        e_held_n = 1;
      end else if (!ex_md_start && lu) begin
        exp_ctrl = 6'b110010;
      end
    end else begin
      if (md_done || m_held == C_TMO - 1) begin
        e_busy_n = 1'b0;
        e_held_n = 0;
        e_tmo_n  = !md_done;
      end else begin
        exp_ctrl = 6'b110101;
        e_held_n = m_held + 1;
      end
    end
  endtask

  function automatic longint sat_inc(longint v, bit en, longint mx);
    return (en && v < mx) ? v + 1 : v;
  endfunction

  task automatic tick();
    eval_model();
    if (rst) begin
      m_stall = 0; m_flush = 0; m_stall_s = 0; m_flush_s = 0;
    end else begin
      m_stall   = sat_inc(m_stall,   exp_ctrl[5], C_MAX);
      m_stall_s = sat_inc(m_stall_s, exp_ctrl[5], C_MAXS);
      m_flush   = sat_inc(m_flush,   e_flush,     C_MAX);
      m_flush_s = sat_inc(m_flush_s, e_flush,     C_MAXS);
    end
    m_tmo  = rst ? 1'b0 : e_tmo_n;
    m_busy = e_busy_n;
    m_held = e_held_n;
    @(posedge clk);
    #1;
  endtask

  task automatic set_idle();
    id_rs1 = 0; id_rs2 = 0; id_use_rs1 = 0; id_use_rs2 = 0; ex_rd = 0;
    ex_mem_read = 0; ex_redirect = 0; ex_md_start = 0; md_done = 0;
  endtask

  task automatic do_reset();
    set_idle();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    for (int i = 0; i < 2; i++) begin
      {id_rs1, id_rs2, ex_rd} = 15'($urandom);
      {id_use_rs1, id_use_rs2, ex_mem_read, ex_redirect, ex_md_start, md_done} = 6'($urandom);
      #1;
      tests++;
      if (ctrl !== 6'b0 || s_ctrl !== 6'b0) begin
        failed++;
        $display("FAIL reset_ctrl cycle %0d got %b/%b expected 000000", i, ctrl, s_ctrl);
      end
      tick();
    end
    rst = 1'b0;
    set_idle();
    #1;
    tests++;
    if (stall_cnt !== 0 || flush_cnt !== 0 || md_timeout !== 1'b0 || ctrl !== 6'b0) begin
      failed++;
      $display("FAIL reset_state got stall=%0d flush=%0d tmo=%b ctrl=%b expected 0/0/0/000000",
               stall_cnt, flush_cnt, md_timeout, ctrl);
    end
  endtask

  task automatic test_load_use();
    do_reset();
    ex_mem_read = 1; ex_rd = 5; id_use_rs2 = 1; id_rs2 = 5; id_rs1 = 3; id_use_rs1 = 1;
    #1;
    tests++;
    if (ctrl !== 6'b110010) begin
      failed++;
      $display("FAIL load_use_ctrl got %b expected 110010", ctrl);
    end
    tick();
    set_idle();
    #1;
    tests++;
    if (ctrl !== 6'b0 || stall_cnt !== 1) begin
      failed++;
      $display("FAIL load_use_after got ctrl=%b stall=%0d expected 000000/1", ctrl, stall_cnt);
    end
    ex_mem_read = 1; ex_rd = 0; id_use_rs2 = 1; id_rs2 = 0;
    #1;
    tests++;
    if (ctrl !== 6'b0) begin
      failed++;
      $display("FAIL load_use_x0 got %b expected 000000", ctrl);
    end
    tick();
    set_idle();
    #1;
    tests++;
    if (stall_cnt !== 1) begin
      failed++;
      $display("FAIL load_use_x0_cnt got %0d expected 1", stall_cnt);
    end
  endtask

  task automatic test_redirect_lu();
    do_reset();
    ex_redirect = 1; ex_mem_read = 1; ex_rd = 9; id_use_rs1 = 1; id_rs1 = 9;
    #1;
    tests++;
    if (ctrl !== 6'b001010) begin
      failed++;
      $display("FAIL redirect_ctrl got %b expected 001010", ctrl);
    end
    tick();
    set_idle();
    #1;
    tests++;
    if (flush_cnt !== 1 || stall_cnt !== 0) begin
      failed++;
      $display("FAIL redirect_cnt got flush=%0d stall=%0d expected 1/0", flush_cnt, stall_cnt);
    end
  endtask

  task automatic test_muldiv();
    do_reset();
    ex_md_start = 1;
    for (int i = 0; i < 4; i++) begin
      // a hazard and redirect during the hold must be ignored
      ex_redirect = (i == 2); ex_mem_read = 1; ex_rd = 4; id_use_rs1 = 1; id_rs1 = 4;
      #1;
      tests++;
      if (ctrl !== 6'b110101) begin
        failed++;
        $display("FAIL md_hold cycle %0d got %b expected 110101", i, ctrl);
      end
      tick();
    end
    ex_redirect = 0; ex_mem_read = 0; md_done = 1;
    #1;
    tests++;
    if (ctrl !== 6'b0) begin
      failed++;
      $display("FAIL md_release got %b expected 000000", ctrl);
    end
    tick();
    set_idle();
    ex_mem_read = 1; ex_rd = 7; id_use_rs2 = 1; id_rs2 = 7;
    #1;
    tests++;
    if (ctrl !== 6'b110010 || stall_cnt !== 4 || flush_cnt !== 0 || md_timeout !== 1'b0) begin
      failed++;
      $display("FAIL md_after got ctrl=%b stall=%0d flush=%0d tmo=%b expected 110010/4/0/0",
               ctrl, stall_cnt, flush_cnt, md_timeout);
    end
    tick();
    set_idle();
  endtask

  task automatic test_timeout();
    do_reset();
    ex_md_start = 1;
    for (int i = 0; i < C_TMO - 1; i++) begin
      #1;
      tests++;
      if (ctrl !== 6'b110101 || md_timeout !== 1'b0) begin
        failed++;
        $display("FAIL tmo_hold cycle %0d got ctrl=%b tmo=%b expected 110101/0", i, ctrl, md_timeout);
      end
      tick();
    end
    #1;
    tests++;
    if (ctrl !== 6'b0 || md_timeout !== 1'b0) begin
      failed++;
      $display("FAIL tmo_release got ctrl=%b tmo=%b expected 000000/0", ctrl, md_timeout);
    end
    tick();
    ex_md_start = 0;
    #1;
    tests++;
    if (md_timeout !== 1'b1 || s_md_timeout !== 1'b1 || stall_cnt !== C_TMO - 1 || ctrl !== 6'b0) begin
      failed++;
      $display("FAIL tmo_pulse got tmo=%b/%b stall=%0d ctrl=%b expected 1/1/%0d/000000",
               md_timeout, s_md_timeout, stall_cnt, ctrl, C_TMO - 1);
    end
    tick();
    #1;
    tests++;
    if (md_timeout !== 1'b0) begin
      failed++;
      $display("FAIL tmo_pulse_end got %b expected 0", md_timeout);
    end
  endtask

  task automatic test_saturation();
    do_reset();
    ex_mem_read = 1; ex_rd = 12; id_use_rs1 = 1; id_rs1 = 12;
    repeat (10) tick();
    set_idle();
    #1;
    tests++;
    if (s_stall_cnt !== 3'd7 || stall_cnt !== 10) begin
      failed++;
      $display("FAIL sat_stall got sat=%0d wide=%0d expected 7/10", s_stall_cnt, stall_cnt);
    end
    ex_redirect = 1;
    repeat (9) tick();
    set_idle();
    #1;
    tests++;
    if (s_flush_cnt !== 3'd7 || flush_cnt !== 9) begin
      failed++;
      $display("FAIL sat_flush got sat=%0d wide=%0d expected 7/9", s_flush_cnt, flush_cnt);
    end
  endtask

  task automatic test_mid_reset();
    do_reset();
    ex_redirect = 1;
    tick();
    ex_redirect = 0;
    ex_md_start = 1;
    repeat (C_TMO - 2) tick();
    rst = 1;
    #1;
    tests++;
    if (ctrl !== 6'b0) begin
      failed++;
      $display("FAIL midrst_ctrl got %b expected 000000", ctrl);
    end
    tick();
    rst = 0;
    set_idle();
    for (int i = 0; i < C_TMO; i++) begin
      #1;
      tests++;
      if (ctrl !== 6'b0 || md_timeout !== 1'b0 || stall_cnt !== 0 || flush_cnt !== 0) begin
        failed++;
        $display("FAIL midrst_after cycle %0d got ctrl=%b tmo=%b stall=%0d flush=%0d expected all 0",
                 i, ctrl, md_timeout, stall_cnt, flush_cnt);
      end
      tick();
    end
  endtask

  task automatic test_random();
    int errs;
    errs = 0;
    do_reset();
    for (int i = 0; i < 800; i++) begin
      id_rs1      = 5'($urandom_range(0, 3));
      id_rs2      = 5'($urandom_range(0, 3));
      ex_rd       = 5'($urandom_range(0, 3));
      id_use_rs1  = 1'($urandom);
      id_use_rs2  = 1'($urandom);
      ex_mem_read = 1'($urandom);
      ex_redirect = ($urandom_range(0, 7) == 0);
      ex_md_start = m_busy ? 1'b1 : ($urandom_range(0, 5) == 0);
      md_done     = ($urandom_range(0, 9) == 0);
      rst         = ($urandom_range(0, 199) == 0);
      #1;
      eval_model();
      tests++;
      if (ctrl !== exp_ctrl || s_ctrl !== exp_ctrl || md_timeout !== m_tmo || s_md_timeout !== m_tmo ||
          stall_cnt !== m_stall[C_CW-1:0] || flush_cnt !== m_flush[C_CW-1:0] ||
          s_stall_cnt !== m_stall_s[C_CWS-1:0] || s_flush_cnt !== m_flush_s[C_CWS-1:0]) begin
        failed++;
        errs++;
        if (errs <= 10)
          $display("FAIL random cycle %0d got ctrl=%b tmo=%b stall=%0d flush=%0d sat=%0d/%0d expected ctrl=%b tmo=%b stall=%0d flush=%0d sat=%0d/%0d",
                   i, ctrl, md_timeout, stall_cnt, flush_cnt, s_stall_cnt, s_flush_cnt,
                   exp_ctrl, m_tmo, m_stall, m_flush, m_stall_s, m_flush_s);
      end
      tick();
    end
    rst = 0;
    set_idle();
  endtask

  initial begin
    m_busy = 0; m_held = 0; m_tmo = 0;
    m_stall = 0; m_flush = 0; m_stall_s = 0; m_flush_s = 0;
    rst = 1;
    set_idle();
    @(posedge clk);
    #1;
    test_reset();
    test_load_use();
    test_redirect_lu();
    test_muldiv();
    test_timeout();
    test_saturation();
    test_mid_reset();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
`default_nettype wire
